// File: rtl/sync_down_timer.sv
// ---------------------------------------------------------------------------
// sync_down_timer
//   Loadable down-counter with a one-cycle terminal-count pulse.
//   A start loads load_val and counts down one step per unpaused edge. When
//   the count steps from 1 to 0, tc pulses for one cycle.
//
//   Optional feature: define SYNC_DOWN_TIMER_AUTO_RELOAD_EN for periodic
//   mode. In that mode, a terminal edge reloads the value captured at start
//   and the timer stays in RUN. Only stop or rst leave RUN in that mode.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   load load_val and begin counting
//   stop     in   abort count, no tc
//   pause    in   hold the count while high (RUN only)
//   load_val in   [WIDTH-1:0] start value N
//   q        out  [WIDTH-1:0] current count (registered)
//   busy     out  high while in RUN (registered)
//   tc       out  terminal-count pulse (registered)
//
// Input priority on each edge: rst > stop > start > pause.
// ---------------------------------------------------------------------------
module sync_down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_nx;
   logic             busy_nx;
   logic             tc_nx;
   logic             load_zero;
   logic             terminal;

`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload, reload_nx;
`endif

   assign load_zero = (load_val == '0);
   // q<=1 rather than q==1, so a stray zero in RUN can never wrap to all-ones.
   assign terminal  = (state == RUN) && !pause && (q <= WIDTH'(1));

   // State register, including the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         q      <= '0;
         busy   <= 1'b0;
         tc     <= 1'b0;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         state  <= state_nx;
         q      <= q_nx;
         busy   <= busy_nx;
         tc     <= tc_nx;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         reload <= reload_nx;
`endif
      end
   end

   // Next-state and next-count logic.
   always_comb begin
      state_nx  = state;
      q_nx      = q;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_nx = reload;
`endif
      if (stop) begin
         // In IDLE, stop is a no-op, and it also masks a same-edge start.
         if (state == RUN) begin
            state_nx = IDLE;
            q_nx     = '0;
         end
      end else if (start) begin
         // A start with N=0 terminates immediately and does not enter RUN.
         q_nx     = load_val;
         state_nx = load_zero ? IDLE : RUN;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         if (!load_zero) reload_nx = load_val;
`endif
      end else if (terminal) begin
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         q_nx     = reload;
`else
         q_nx     = '0;
         state_nx = IDLE;
`endif
      end else if (state == RUN && !pause) begin
         q_nx = q - WIDTH'(1);
      end
   end

   // Output logic, computed from the same edge decisions.
   always_comb begin
      busy_nx = (state_nx == RUN);
      tc_nx   = 1'b0;
      if (!stop) begin
         if (start) tc_nx = load_zero;
         else       tc_nx = terminal;
      end
   end

endmodule

// File: doc/sync_down_timer.md
SYNC_DOWN_TIMER -- requirements
Module: sync_down_timer

Interface
REQ-001 Parameter: WIDTH, 4, counter and load-value width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  load load_val and begin counting down; sampled each rising edge.
REQ-005 Port: stop  input  1  abort the current count without a terminal pulse.
REQ-006 Port: pause  input  1  freeze the count while high.
REQ-007 Port: load_val  input  WIDTH  start value N, sampled only on edges where start is accepted.
REQ-008 Port: q  output  WIDTH  current count, registered.
REQ-009 Port: busy  output  1  high while in RUN, registered.
REQ-010 Port: tc  output  1  terminal-count pulse, one cycle wide, registered.

Function
REQ-011 States SHALL be IDLE and RUN only; encoding is free.
REQ-012 Input priority per edge SHALL be rst > stop > start > pause.
REQ-013 IDLE, start=1, load_val=N≠0: next edge q=N, busy=1, state RUN, tc=0.
REQ-014 IDLE, start=1, load_val=0: next edge q=0, tc=1 for one cycle, state stays IDLE, busy=0.
REQ-015 IDLE without start: q, busy and state hold, tc=0; pause and stop have no effect.
REQ-016 RUN, pause=1, no start/stop: q holds, busy=1, tc=0.
REQ-017 RUN, pause=0, q>1: q decrements by 1 per edge.
REQ-018 RUN, pause=0, q=1 (terminal edge): q=0, tc=1, busy=0, state IDLE (non-reload build).
REQ-019 Latency: start accepted at edge k with N≠0 and no pause gives q=N after edge k and tc high for exactly the cycle after edge k+N.
REQ-020 q SHALL never decrement below 0; no wrap to all-ones in any build.
REQ-021 RUN, start=1, stop=0: restart; q=load_val, no tc this edge; load_val=0 behaves as REQ-014 and returns to IDLE.
REQ-022 RUN, stop=1: next edge q=0, busy=0, tc=0, state IDLE; this holds even when the same edge is a terminal edge.
REQ-023 tc SHALL deassert on the edge after any edge that asserted it unless that next edge is itself terminal.

Reset
REQ-024 rst=1 at a rising edge SHALL force q=0, busy=0, tc=0, state IDLE and reload register=0, overriding all other inputs.
REQ-025 Reset mid-count SHALL discard the count with no tc; the first edge with rst=0 obeys IDLE rules.
REQ-026 Output values before the first reset edge are unspecified; an initial value of zero is permitted.

Configuration
REQ-027 Macro SYNC_DOWN_TIMER_AUTO_RELOAD_EN SHALL select periodic mode.
REQ-028 When defined, an accepted start with N≠0 SHALL also capture load_val into a WIDTH-bit reload register.
REQ-029 When defined, a terminal edge SHALL set q=reload value and tc=1, with busy=1 and state RUN retained, giving one tc per N unpaused cycles; only stop or rst leaves RUN.
REQ-030 When undefined, no reload register SHALL exist and REQ-018 applies.

Verification
REQ-031 Reset, then start with load_val=5 for one cycle: q=5,4,3,2,1,0 on successive edges; busy 1→0 and tc=1 on the q=0 edge only.
REQ-032 load_val=4 start, pause high for 3 cycles after q=2: q holds at 2 for 3 cycles; tc arrives exactly 3 cycles later than unpaused.
REQ-033 Start with load_val=0: tc=1 for one cycle, busy stays 0, q=0; start with stop in the same cycle: no state change.
REQ-034 load_val=6 run, rst at q=3: next edge q=0, busy=0, tc=0; stop at q=1: tc never pulses.
REQ-035 Restart at q=2 with load_val=9: q=9 next edge, no tc, then counts to 0.
REQ-036 With SYNC_DOWN_TIMER_AUTO_RELOAD_EN and load_val=3: q=3,2,1,3,2,1,...; tc every 3rd cycle; busy constant 1 until stop.
